// File: rtl/avalon_result_writer_if.sv
// Avalon-MM write-master bus bundle used between avalon_result_writer and the memory side.
// Only the write subset is carried; the master never reads.
interface avalon_result_writer_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
);
    logic [ADDR_W-1:0]   avm_address;
    logic                avm_write;
    logic [DATA_W-1:0]   avm_writedata;
    logic [DATA_W/8-1:0] avm_byteenable;
    logic                avm_waitrequest;

    modport master (
        output avm_address,
        output avm_write,
        output avm_writedata,
        output avm_byteenable,
        input  avm_waitrequest
    );

    modport slave (
        input  avm_address,
        input  avm_write,
        input  avm_writedata,
        input  avm_byteenable,
        output avm_waitrequest
    );
endinterface

// File: rtl/avalon_result_writer.sv
// Snapshots the C results on start, writes one result per 64-bit word from BASE_ADDR,
// then writes a trailer {checksum, 16'hC0DE, NUM_ROWS} and pulses done.
module avalon_result_writer #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 64,
    parameter int NUM_ROWS  = 8,
    parameter int C_W       = 24,
    parameter int BASE_ADDR = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [C_W-1:0]        c_data [NUM_ROWS],
    avalon_result_writer_if.master avm,
    output logic                  busy,
    output logic                  done,
    output logic [1:0]            dbg_state,
    output logic [3:0]            dbg_row
);
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WRITE   = 2'd1,
        ST_TRAILER = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    localparam int                SUM_W     = C_W + 4;
    localparam logic [3:0]        LAST_ROW  = 4'(NUM_ROWS - 1);
    localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
    localparam logic [15:0]       SIGNATURE = 16'hC0DE;

    state_t             state_q, state_d;
    logic [3:0]         row_q, row_d;
    logic [SUM_W-1:0]   sum_q, sum_d;
    logic [C_W-1:0]     snap_q [NUM_ROWS];
    logic [C_W-1:0]     cur_word;
    logic               capture;

    // Snapshot registers are loaded only on an accepted start, so later c_data changes are invisible.
    for (genvar gi = 0; gi < NUM_ROWS; gi++) begin : g_snap
        always_ff @(posedge clk) begin
            if (rst) begin
                snap_q[gi] <= '0;
            end else if (capture) begin
                snap_q[gi] <= c_data[gi];
            end
        end
    end

    always_comb begin
        cur_word = '0;
        for (int i = 0; i < NUM_ROWS; i++) begin
            if (row_q == 4'(i)) begin
                cur_word = snap_q[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            row_q   <= '0;
            sum_q   <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            sum_q   <= sum_d;
        end
    end

    // Bus outputs decode straight from registered state, so they stay put while stalled.
    always_comb begin
        state_d            = state_q;
        row_d              = row_q;
        sum_d              = sum_q;
        capture            = 1'b0;
        done               = 1'b0;
        avm.avm_write      = 1'b0;
        avm.avm_address    = '0;
        avm.avm_writedata  = '0;
        avm.avm_byteenable = '0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    capture = 1'b1;
                    sum_d   = '0;
                    row_d   = '0;
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                avm.avm_write      = 1'b1;
                avm.avm_address    = BASE + ADDR_W'(row_q);
                avm.avm_writedata  = DATA_W'(cur_word);
                avm.avm_byteenable = '1;
                if (!avm.avm_waitrequest) begin
                    sum_d = sum_q + SUM_W'(cur_word);
                    if (row_q == LAST_ROW) begin
                        state_d = ST_TRAILER;
                    end else begin
                        row_d = row_q + 4'd1;
                    end
                end
            end
            ST_TRAILER: begin
                avm.avm_write      = 1'b1;
                avm.avm_address    = BASE + ADDR_W'(NUM_ROWS);
                avm.avm_writedata  = DATA_W'({32'(sum_q), SIGNATURE, 16'(NUM_ROWS)});
                avm.avm_byteenable = '1;
                if (!avm.avm_waitrequest) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                row_d   = '0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy      = (state_q != ST_IDLE);
    assign dbg_state = state_q;
    assign dbg_row   = row_q;
endmodule

// File: tb/tb_avalon_result_writer.sv
// Directed bench for avalon_result_writer: a negedge monitor logs accepted writes and done
// pulses, and each scenario task compares that log against hand-computed words.
module tb_avalon_result_writer;
    localparam int NR = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [23:0] c_data [NR];
    logic        busy, done;
    logic [1:0]  dbg_state;
    logic [3:0]  dbg_row;
    int          cyc = 0;
    int          tests_run = 0;
    int          tests_failed = 0;

    logic [31:0] log_addr[$];
    logic [63:0] log_data[$];
    int          log_cyc[$];
    int          done_cyc[$];

    avalon_result_writer_if #(.ADDR_W(32), .DATA_W(64)) avm_bus ();

    avalon_result_writer #(
        .ADDR_W(32), .DATA_W(64), .NUM_ROWS(NR), .C_W(24), .BASE_ADDR(16)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .c_data(c_data), .avm(avm_bus),
        .busy(busy), .done(done), .dbg_state(dbg_state), .dbg_row(dbg_row)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Inputs change only just after a rising edge, so the negedge view is what the next edge samples.
    always @(negedge clk) begin
        if (avm_bus.avm_write === 1'b1 && avm_bus.avm_waitrequest === 1'b0) begin
            log_addr.push_back(avm_bus.avm_address);
            log_data.push_back(avm_bus.avm_writedata);
            log_cyc.push_back(cyc);
        end
        if (done === 1'b1) done_cyc.push_back(cyc);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        log_addr.delete();
        log_data.delete();
        log_cyc.delete();
        done_cyc.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        avm_bus.avm_waitrequest = 1'b0;
        for (int i = 0; i < NR; i++) c_data[i] = 24'h5A5A5A;
        tick();
        tick();
        tests_run++;
        if ({avm_bus.avm_write, avm_bus.avm_address, avm_bus.avm_writedata, avm_bus.avm_byteenable} !== '0) begin
            tests_failed++;
            $display("FAIL reset_bus: write=%b addr=%h data=%h be=%h, required all zero",
                     avm_bus.avm_write, avm_bus.avm_address, avm_bus.avm_writedata, avm_bus.avm_byteenable);
        end
        tests_run++;
        if ({busy, done, dbg_state, dbg_row} !== 8'h00) begin
            tests_failed++;
            $display("FAIL reset_status: busy=%b done=%b state=%0d row=%0d, required 0 0 0 0",
                     busy, done, dbg_state, dbg_row);
        end
        // start coinciding with rst must be ignored
        start = 1'b1;
        tick();
        rst = 1'b0;
        start = 1'b0;
        tick();
        tests_run++;
        if (busy !== 1'b0 || dbg_state !== 2'd0) begin
            tests_failed++;
            $display("FAIL reset_beats_start: busy=%b state=%0d, required 0 0", busy, dbg_state);
        end
    endtask

    task automatic test_basic();
        int s;
        logic [63:0] exp_data [NR+1];
        clear_logs();
        for (int i = 0; i < NR; i++) begin
            c_data[i] = 24'(i + 1);
            exp_data[i] = 64'(i + 1);
        end
        exp_data[NR] = 64'h00000024_C0DE_0008;
        start = 1'b1;
        tick();
        start = 1'b0;
        s = cyc;
        for (int k = 0; k < 12; k++) begin
            if (k == 0) begin
                tests_run++;
                if (dbg_state !== 2'd1 || busy !== 1'b1 || avm_bus.avm_byteenable !== 8'hFF) begin
                    tests_failed++;
                    $display("FAIL basic_first_write: state=%0d busy=%b be=%h, required 1 1 ff",
                             dbg_state, busy, avm_bus.avm_byteenable);
                end
            end
            if (k == NR) begin
                tests_run++;
                if (dbg_state !== 2'd2 || dbg_row !== 4'd7) begin
                    tests_failed++;
                    $display("FAIL basic_trailer_state: state=%0d row=%0d, required 2 7", dbg_state, dbg_row);
                end
            end
            if (k == NR + 2) begin
                tests_run++;
                if (busy !== 1'b0 || dbg_row !== 4'd0) begin
                    tests_failed++;
                    $display("FAIL basic_idle_after_done: busy=%b row=%0d, required 0 0", busy, dbg_row);
                end
            end
            tick();
        end
        tests_run++;
        if (log_addr.size() != NR + 1) begin
            tests_failed++;
            $display("FAIL basic_count: %0d writes, required %0d", log_addr.size(), NR + 1);
        end
        for (int i = 0; i < NR + 1 && i < log_addr.size(); i++) begin
            tests_run++;
            if (log_addr[i] !== 32'(16 + i) || log_data[i] !== exp_data[i] || log_cyc[i] != s + i) begin
                tests_failed++;
                $display("FAIL basic_word%0d: addr=%0d data=%h cyc=%0d, required addr=%0d data=%h cyc=%0d",
                         i, log_addr[i], log_data[i], log_cyc[i] - s, 16 + i, exp_data[i], i);
            end
        end
        // done sits in cycle NR+2 counting the start edge as edge 0, i.e. offset NR+1 from s
        tests_run++;
        if (done_cyc.size() != 1 || done_cyc[0] != s + NR + 1) begin
            tests_failed++;
            $display("FAIL basic_done: %0d pulses, first at offset %0d, required 1 at %0d",
                     done_cyc.size(), (done_cyc.size() > 0) ? done_cyc[0] - s : -1, NR + 1);
        end
    endtask

    task automatic test_stall();
        int s;
        logic [63:0] trailer;
        trailer = 64'h00000024_C0DE_0008;
        clear_logs();
        for (int i = 0; i < NR; i++) c_data[i] = 24'(i + 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        s = cyc;
        for (int k = 0; k < 18; k++) begin
            avm_bus.avm_waitrequest = ((k >= 2 && k <= 4) || (k >= 11 && k <= 13));
            if (k >= 2 && k <= 4) begin
                tests_run++;
                if (avm_bus.avm_write !== 1'b1 || avm_bus.avm_address !== 32'd18 || avm_bus.avm_writedata !== 64'd3) begin
                    tests_failed++;
                    $display("FAIL stall_row2_hold k=%0d: write=%b addr=%0d data=%h, required 1 18 3",
                             k, avm_bus.avm_write, avm_bus.avm_address, avm_bus.avm_writedata);
                end
            end
            if (k >= 11 && k <= 13) begin
                tests_run++;
                if (avm_bus.avm_write !== 1'b1 || avm_bus.avm_address !== 32'd24 || avm_bus.avm_writedata !== trailer) begin
                    tests_failed++;
                    $display("FAIL stall_trailer_hold k=%0d: write=%b addr=%0d data=%h, required 1 24 %h",
                             k, avm_bus.avm_write, avm_bus.avm_address, avm_bus.avm_writedata, trailer);
                end
            end
            tick();
        end
        avm_bus.avm_waitrequest = 1'b0;
        tests_run++;
        if (log_addr.size() != NR + 1) begin
            tests_failed++;
            $display("FAIL stall_count: %0d writes, required %0d", log_addr.size(), NR + 1);
        end
        for (int i = 0; i < NR + 1 && i < log_addr.size(); i++) begin
            tests_run++;
            if (log_addr[i] !== 32'(16 + i) || log_data[i] !== ((i == NR) ? trailer : 64'(i + 1))) begin
                tests_failed++;
                $display("FAIL stall_word%0d: addr=%0d data=%h", i, log_addr[i], log_data[i]);
            end
        end
        tests_run++;
        if (done_cyc.size() != 1 || done_cyc[0] != s + NR + 7) begin
            tests_failed++;
            $display("FAIL stall_done: %0d pulses, first at offset %0d, required 1 at %0d",
                     done_cyc.size(), (done_cyc.size() > 0) ? done_cyc[0] - s : -1, NR + 7);
        end
    endtask

    task automatic test_saturation();
        logic [63:0] trailer;
        trailer = 64'h07FFFFF8_C0DE_0008;
        clear_logs();
        for (int i = 0; i < NR; i++) c_data[i] = 24'hFFFFFF;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (12) tick();
        tests_run++;
        if (log_addr.size() != NR + 1 || done_cyc.size() != 1) begin
            tests_failed++;
            $display("FAIL sat_count: %0d writes %0d done, required %0d 1", log_addr.size(), done_cyc.size(), NR + 1);
        end
        for (int i = 0; i < NR + 1 && i < log_data.size(); i++) begin
            tests_run++;
            if (log_data[i] !== ((i == NR) ? trailer : 64'h0000000000FFFFFF)) begin
                tests_failed++;
                $display("FAIL sat_word%0d: data=%h", i, log_data[i]);
            end
        end
    endtask

    task automatic test_snapshot();
        logic [63:0] trailer;
        trailer = 64'h00000240_C0DE_0008;
        clear_logs();
        for (int i = 0; i < NR; i++) c_data[i] = 24'(16 * (i + 1));
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 14; k++) begin
            if (k == 4) begin
                for (int i = 0; i < NR; i++) c_data[i] = 24'hABCDEF;
            end
            // restart attempts mid-row and during the DONE cycle
            start = (k == 4 || k == NR + 1);
            if (k == NR + 3) begin
                tests_run++;
                if (busy !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL snap_no_restart: busy=%b, required 0", busy);
                end
            end
            tick();
        end
        start = 1'b0;
        tests_run++;
        if (log_addr.size() != NR + 1 || done_cyc.size() != 1) begin
            tests_failed++;
            $display("FAIL snap_count: %0d writes %0d done, required %0d 1", log_addr.size(), done_cyc.size(), NR + 1);
        end
        for (int i = 0; i < NR + 1 && i < log_data.size(); i++) begin
            tests_run++;
            if (log_addr[i] !== 32'(16 + i) || log_data[i] !== ((i == NR) ? trailer : 64'(16 * (i + 1)))) begin
                tests_failed++;
                $display("FAIL snap_word%0d: addr=%0d data=%h", i, log_addr[i], log_data[i]);
            end
        end
    endtask

    task automatic test_reset_midop();
        int s;
        clear_logs();
        for (int i = 0; i < NR; i++) c_data[i] = 24'(i + 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 7; k++) begin
            avm_bus.avm_waitrequest = (k >= 5);
            rst = (k == 6);
            tick();
        end
        tests_run++;
        if (avm_bus.avm_write !== 1'b0 || busy !== 1'b0 || dbg_state !== 2'd0 || dbg_row !== 4'd0) begin
            tests_failed++;
            $display("FAIL midrst_abort: write=%b busy=%b state=%0d row=%0d, required 0 0 0 0",
                     avm_bus.avm_write, busy, dbg_state, dbg_row);
        end
        rst = 1'b0;
        avm_bus.avm_waitrequest = 1'b0;
        repeat (12) tick();
        tests_run++;
        if (log_addr.size() != 5 || done_cyc.size() != 0) begin
            tests_failed++;
            $display("FAIL midrst_partial: %0d writes %0d done, required 5 0", log_addr.size(), done_cyc.size());
        end
        clear_logs();
        start = 1'b1;
        tick();
        start = 1'b0;
        s = cyc;
        repeat (12) tick();
        tests_run++;
        if (log_addr.size() != NR + 1 || done_cyc.size() != 1) begin
            tests_failed++;
            $display("FAIL midrst_rerun_count: %0d writes %0d done, required %0d 1", log_addr.size(), done_cyc.size(), NR + 1);
        end
        for (int i = 0; i < NR + 1 && i < log_data.size(); i++) begin
            tests_run++;
            if (log_addr[i] !== 32'(16 + i) || log_cyc[i] != s + i ||
                log_data[i] !== ((i == NR) ? 64'h00000024_C0DE_0008 : 64'(i + 1))) begin
                tests_failed++;
                $display("FAIL midrst_rerun_word%0d: addr=%0d data=%h offset=%0d", i, log_addr[i], log_data[i], log_cyc[i] - s);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_saturation();
        test_snapshot();
        test_reset_midop();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/avalon_result_writer.md
Name: avalon_result_writer

Overview:
- Avalon-MM write master. It is the write-side counterpart of avalon_fifo_loader.
- When matrix_vector_multi finishes, this block snapshots the 8 x 24-bit C_matrix results.
- It writes them back into the mem_wrapper address space, one result per 64-bit word.
- It then writes one trailer word holding a checksum and a signature.

Parameters:
- ADDR_W, 32, Avalon address width. Addresses are word indices, in the same units as the loader.
- DATA_W, 64, Avalon writedata width.
- NUM_ROWS, 8, number of C results to write. Legal range is 1..15.
- C_W, 24, width of each C result.
- BASE_ADDR, 16, word address of C[0]. C[i] goes to BASE_ADDR+i and the trailer goes to BASE_ADDR+NUM_ROWS.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse, driven from the compute engine's done output.
- c_data  in  NUM_ROWS x C_W  unpacked result array (C_matrix).
- avm_address  out  ADDR_W  write word address.
- avm_write  out  1  write request.
- avm_writedata  out  DATA_W  write data.
- avm_byteenable  out  DATA_W/8  byte enables.
- avm_waitrequest  in  1  slave stall.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle pulse after the trailer write is accepted.
- dbg_state  out  2  encoding: IDLE=0, WRITE=1, TRAILER=2, DONE=3.
- dbg_row  out  4  current row index.

Behaviour:
- Reset (rst high at a clock edge): next cycle, and for as long as rst is held:
  - state=IDLE, row=0, avm_write=0, avm_address=0, avm_writedata=0, avm_byteenable=0;
  - busy=0, done=0, dbg_row=0;
  - snapshot registers and checksum accumulator cleared.
- IDLE:
  - start=1 at an edge copies c_data into snapshot registers, clears sum and row, and moves to WRITE.
  - avm_write is asserted in the following cycle, so latency from start to first write is 1 cycle.
- WRITE:
  - avm_write=1, avm_address=BASE_ADDR+row.
  - avm_writedata = zero-extended snap[row] (bits 63:C_W are zero).
  - avm_byteenable = all ones.
  - A transfer is accepted at an edge where avm_write=1 and avm_waitrequest=0.
  - While waitrequest=1, address, data, byteenable and write are held stable.
  - On accept: sum += snap[row]. If row==NUM_ROWS-1, go to TRAILER; otherwise row++ and stay in WRITE. There are no idle bubbles between back-to-back writes.
- TRAILER:
  - avm_write=1, avm_address=BASE_ADDR+NUM_ROWS.
  - avm_writedata = {sum zero-extended to 32 bits, 16'hC0DE, 16'(NUM_ROWS)}.
  - Sum width is C_W+4 bits; no overflow is possible for the legal NUM_ROWS range.
  - On accept: go to DONE.
- DONE: done=1 and avm_write=0 for exactly one cycle, then IDLE.
- avm_write is deasserted in IDLE and DONE. Address and data outputs in those states are don't-care but must not X-propagate.
- Throughput: with waitrequest tied low, start sampled at edge 0 gives:
  - writes in cycles 1..NUM_ROWS+1;
  - done in cycle NUM_ROWS+2;
  - ready for a new start at the following edge.
- start while busy=1 (including during DONE) is ignored. No queuing and no restart.
- c_data is sampled only at the accepted start edge. Later changes to c_data do not affect the words written.
- rst mid-transfer:
  - the block aborts and avm_write drops next cycle, even if waitrequest is high;
  - this deliberate protocol break is acceptable because memory is reset at the same time;
  - no done pulse is issued.
- start and rst asserted at the same edge: rst wins.
- dbg_row mirrors row. It holds NUM_ROWS-1 during TRAILER and 0 in IDLE.

Test Plan:
- Basic: set c_data[i]=i+1, waitrequest=0, pulse start.
  - Required: writes 0x1..0x8 to addresses 16..23 on consecutive cycles.
  - Required: trailer at address 24 = 64'h00000024_C0DE_0008.
  - Required: done pulses exactly once, 10 cycles after start; busy is low the next cycle.
- Stall: hold waitrequest=1 for 3 cycles on row 2 and on the trailer, otherwise 0.
  - Required: address and data are held stable through each stall; no write is duplicated or skipped.
  - Required: done appears 6 cycles later than in the Basic case.
- Saturation: all c_data=24'hFFFFFF.
  - Required: each row word = 64'h0000000000FFFFFF.
  - Required: trailer sum field = 32'h07FFFFF8.
- Snapshot/ignore: change c_data and pulse start again during row 4.
  - Required: memory receives the original values; only one transaction sequence and one done pulse occur.
- Reset mid-op: assert rst for 1 cycle during row 5 while waitrequest=1.
  - Required: avm_write=0, busy=0 and dbg_state=0 next cycle; no done pulse.
  - Required: a subsequent start performs a complete correct sequence from address 16.
- End-to-end: place the block in the system bench after matrix_vector_multi, with start driven by the compute engine's done.
  - Required: mem_wrapper contents at 16..23 equal the displayed C_matrix values.
